// File: rtl/spi_sd.sv
// SPI master for the two SD card slots, mapped as four byte registers at $FE30-$FE33.
// Mode 0, MSB first, SCLK half-period of (DIV+1) MHZ48 cycles.
module spi_sd #(
  parameter logic [7:0] DIV_RESET = 8'd119
) (
  input  logic       MHZ48,
  input  logic       nRES,
  input  logic       nE,
  input  logic       RW,
  input  logic       nSEL,
  input  logic [1:0] A,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       DOE,
  output logic       nSD0,
  output logic       nSD1,
  output logic       MOSI,
  output logic       SCLK,
  input  logic       MISO
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic [1:0]  a_q, a_d;
  logic        rw_q, rw_d;
  logic [7:0]  din_q, din_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        ovr_q, ovr_d;
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  rx_q, rx_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  reload_q, reload_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        nsd0_q, nsd0_d;
  logic        nsd1_q, nsd1_d;

  logic        busy_s;
  logic        commit_s;
  logic        start_s;
  logic [7:0]  status_s;

  assign busy_s   = (state_q != ST_IDLE);
  assign commit_s = nE & pend_q;
  assign status_s = {busy_s, 1'b0, ovr_q, 3'b000, sel_q};

  assign DOE  = ~nE & ~nSEL & RW;
  assign nSD0 = nsd0_q;
  assign nSD1 = nsd1_q;
  assign MOSI = mosi_q;
  assign SCLK = sclk_q;

  // Read data mux, driven straight from the live address lines.
  always_comb begin
    case (A)
      2'd0:    DOUT = rx_data_q;
      2'd1:    DOUT = status_s;
      2'd2:    DOUT = div_q;
      default: DOUT = 8'h00;
    endcase
  end

  // Next-state logic: bus capture/commit, register writes and the shift FSM.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    a_d       = a_q;
    rw_d      = rw_q;
    din_d     = din_q;
    sel_d     = sel_q;
    div_d     = div_q;
    rx_data_d = rx_data_q;
    ovr_d     = ovr_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    bitcnt_d  = bitcnt_q;
    cnt_d     = cnt_q;
    reload_d  = reload_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    start_s   = 1'b0;

    // Capture and commit are mutually exclusive because they need opposite nE levels.
    if (~nE & ~nSEL) begin
      pend_d = 1'b1;
      a_d    = A;
      rw_d   = RW;
      din_d  = DIN;
    end else if (commit_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

    if (commit_s) begin
      if (rw_q) begin
        if (a_q == 2'd1) begin
          ovr_d = 1'b0;
        end else begin
          ovr_d = ovr_q;
        end
      end else begin
        case (a_q)
          2'd0: begin
            if (busy_s) ovr_d = 1'b1;
            else        start_s = 1'b1;
          end
          2'd1: begin
            if (busy_s) ovr_d = 1'b1;
            else        sel_d = din_q[1:0];
          end
          2'd2:    div_d = din_q;
          default: div_d = div_q;
        endcase
      end
    end else begin
      ovr_d = ovr_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          shift_d  = din_q[6:0];
          mosi_d   = din_q[7];
          reload_d = div_q;
          cnt_d    = div_q;
          bitcnt_d = 3'd0;
          state_d  = ST_LO;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LO: begin
        if (cnt_q == 8'd0) begin
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], MISO};
          cnt_d   = reload_q;
          state_d = ST_HI;
        end else begin
          cnt_d   = cnt_q - 8'd1;
        end
      end
      ST_HI: begin
        if (cnt_q == 8'd0) begin
          sclk_d   = 1'b0;
          bitcnt_d = bitcnt_q + 3'd1;
          cnt_d    = reload_q;
          if (bitcnt_q == 3'd7) begin
            rx_data_d = rx_q;
            mosi_d    = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            mosi_d    = shift_q[6];
            shift_d   = {shift_q[5:0], 1'b0};
            state_d   = ST_LO;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        sclk_d  = 1'b0;
        mosi_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    // SEL0 wins over SEL1, so 2'b11 selects only card 0.
    nsd0_d = ~sel_d[0];
    nsd1_d = ~(sel_d[1] & ~sel_d[0]);
  end

  // State and output registers.
  always_ff @(posedge MHZ48 or negedge nRES) begin
    if (!nRES) begin
      state_q   <= ST_IDLE;
      pend_q    <= 1'b0;
      a_q       <= 2'd0;
      rw_q      <= 1'b1;
      din_q     <= 8'h00;
      sel_q     <= 2'b00;
      div_q     <= DIV_RESET;
      rx_data_q <= 8'hFF;
      ovr_q     <= 1'b0;
      shift_q   <= 7'h00;
      rx_q      <= 8'h00;
      bitcnt_q  <= 3'd0;
      cnt_q     <= 8'd0;
      reload_q  <= 8'd0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b1;
      nsd0_q    <= 1'b1;
      nsd1_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      a_q       <= a_d;
      rw_q      <= rw_d;
      din_q     <= din_d;
      sel_q     <= sel_d;
      div_q     <= div_d;
      rx_data_q <= rx_data_d;
      ovr_q     <= ovr_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      bitcnt_q  <= bitcnt_d;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      nsd0_q    <= nsd0_d;
      nsd1_q    <= nsd1_d;
    end
  end

endmodule

// File: tb/tb_spi_sd.sv
// Directed plus randomized bench for spi_sd with a register-level reference model
// and an SD-card slave model that serves MISO and records MOSI.
module tb_spi_sd;

  logic       MHZ48 = 1'b0;
  logic       nRES  = 1'b0;
  logic       nE    = 1'b1;
  logic       RW    = 1'b1;
  logic       nSEL  = 1'b1;
  logic [1:0] A     = 2'd0;
  logic [7:0] DIN   = 8'h00;
  logic [7:0] DOUT;
  logic       DOE;
  logic       nSD0;
  logic       nSD1;
  logic       MOSI;
  logic       SCLK;
  logic       MISO  = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model of the programmer-visible state.
  logic [7:0] m_div  = 8'd119;
  logic [1:0] m_sel  = 2'b00;
  logic [7:0] m_rx   = 8'hFF;
  logic       m_ovr  = 1'b0;
  logic       m_busy = 1'b0;

  spi_sd dut (
    .MHZ48(MHZ48), .nRES(nRES), .nE(nE), .RW(RW), .nSEL(nSEL), .A(A),
    .DIN(DIN), .DOUT(DOUT), .DOE(DOE), .nSD0(nSD0), .nSD1(nSD1),
    .MOSI(MOSI), .SCLK(SCLK), .MISO(MISO)
  );

  always #5 MHZ48 = ~MHZ48;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 6309 bus cycle: two E-low clocks for capture, then E high commits.
  task automatic bus(input logic rw, input logic [1:0] adr, input logic [7:0] wd,
                     output logic [7:0] rd);
    @(negedge MHZ48);
    nSEL = 1'b0; nE = 1'b0; RW = rw; A = adr; DIN = wd;
    @(negedge MHZ48);
    @(negedge MHZ48);
    rd = DOUT;
    check("doe_active", DOE, rw);
    nE = 1'b1;
    @(negedge MHZ48);
    nSEL = 1'b1; RW = 1'b1;
    check("doe_idle", DOE, 1'b0);
  endtask

  task automatic check_cs();
    check("nsd0", nSD0, !m_sel[0]);
    check("nsd1", nSD1, !(m_sel == 2'b10));
  endtask

  task automatic wr(input logic [1:0] adr, input logic [7:0] d);
    logic [7:0] rd;
    bus(1'b0, adr, d, rd);
    case (adr)
      2'd0: if (m_busy) m_ovr = 1'b1;
      2'd1: if (m_busy) m_ovr = 1'b1; else m_sel = d[1:0];
      2'd2: m_div = d;
      default: ;
    endcase
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] adr);
    logic [7:0] rd;
    logic [7:0] exp;
    case (adr)
      2'd0: exp = m_rx;
      2'd1: exp = {m_busy, 1'b0, m_ovr, 3'b000, m_sel};
      2'd2: exp = m_div;
      default: exp = 8'h00;
    endcase
    bus(1'b1, adr, 8'h00, rd);
    check(tag, rd, exp);
    if (adr == 2'd1) m_ovr = 1'b0;
  endtask

  // Slave side: serves MISO bits, records MOSI at each rise and times SCLK phases.
  task automatic monitor(input logic [7:0] tx, input logic [7:0] slave, input int d);
    int cyc = 0;
    int rises = 0;
    int falls = 0;
    int run = 0;
    logic prev_s = 1'b0;
    logic prev_m = tx[7];
    logic s, m;
    logic [7:0] mb = 8'h00;
    while (falls < 8 && cyc <= 16 * (d + 1) + 8) begin
      s = SCLK; m = MOSI;
      if (s && !prev_s) begin
        rises++;
        check("mosi_setup", m, prev_m);
        mb = {mb[6:0], m};
        check("sclk_low_len", run, d + 1);
        run = 1;
      end else if (!s && prev_s) begin
        falls++;
        check("sclk_high_len", run, d + 1);
        run = 1;
        if (rises < 8) MISO = slave[7 - rises];
      end else begin
        run++;
      end
      prev_s = s; prev_m = m;
      if (falls < 8) begin
        @(negedge MHZ48);
        cyc++;
      end
    end
    check("busy_cycles", cyc, 16 * (d + 1));
    check("sclk_pulses", rises, 8);
    check("mosi_byte", mb, tx);
  endtask

  // Bus activity overlapping a transfer.
  task automatic mid_op(input int op, input logic [7:0] val);
    if (op == 1) begin
      wr(2'd0, 8'h55);
      wr(2'd1, 8'h02);
      check_cs();
      rd_chk("data_while_busy", 2'd0);
      rd_chk("status_busy_ovr", 2'd1);
    end else if (op == 2) begin
      wr(2'd2, val);
    end
  endtask

  task automatic do_xfer(input logic [7:0] tx, input logic [7:0] slave,
                         input int op, input logic [7:0] val);
    logic [7:0] rd;
    int d;
    d = int'(m_div);
    MISO = slave[7];
    bus(1'b0, 2'd0, tx, rd);
    m_busy = 1'b1;
    check("first_mosi", MOSI, tx[7]);
    fork
      monitor(tx, slave, d);
      mid_op(op, val);
    join
    m_busy = 1'b0;
    m_rx = slave;
    check("end_sclk", SCLK, 1'b0);
    check("end_mosi", MOSI, 1'b1);
    rd_chk("data_rx", 2'd0);
  endtask

  initial begin
    logic [7:0] tx, sl, v;
    int d, op;

    repeat (3) @(negedge MHZ48);
    check("rst_sclk", SCLK, 1'b0);
    check("rst_mosi", MOSI, 1'b1);
    check_cs();
    nRES = 1'b1;
    @(negedge MHZ48);
    check("rst_doe", DOE, 1'b0);
    rd_chk("rst_data", 2'd0);
    rd_chk("rst_status", 2'd1);
    rd_chk("rst_div", 2'd2);
    rd_chk("rst_rsvd", 2'd3);
    wr(2'd3, 8'h5A);
    rd_chk("rsvd_after_write", 2'd3);

    wr(2'd1, 8'h02);
    check_cs();
    wr(2'd1, 8'h03);
    check_cs();
    rd_chk("status_sel11", 2'd1);

    wr(2'd2, 8'd1);
    wr(2'd1, 8'h01);
    check_cs();
    do_xfer(8'hA5, 8'h3C, 0, 8'h00);

    // Overrun: DATA and CTRL writes while busy are dropped and flag OVR.
    do_xfer(8'hC3, 8'($urandom), 1, 8'h00);
    check_cs();
    rd_chk("status_after_ovr", 2'd1);

    wr(2'd2, 8'd0);
    do_xfer(8'hFF, 8'h00, 0, 8'h00);

    for (int i = 0; i < 4; i++) begin
      d  = $urandom_range(1, 3);
      tx = 8'($urandom);
      sl = 8'($urandom);
      v  = 8'($urandom_range(0, 3));
      op = (i == 1) ? 2 : 0;
      wr(2'd2, 8'(d));
      do_xfer(tx, sl, op, v);
      rd_chk("div_readback", 2'd2);
    end

    // Reset in the middle of bit 4 while SCLK is high.
    wr(2'd2, 8'd1);
    wr(2'd1, 8'h01);
    MISO = 1'b1;
    bus(1'b0, 2'd0, 8'h96, v);
    repeat (18) @(negedge MHZ48);
    check("pre_reset_sclk", SCLK, 1'b1);
    nRES = 1'b0;
    #1;
    check("async_sclk", SCLK, 1'b0);
    check("async_nsd0", nSD0, 1'b1);
    check("async_nsd1", nSD1, 1'b1);
    check("async_mosi", MOSI, 1'b1);
    @(negedge MHZ48);
    nRES = 1'b1;
    m_div = 8'd119; m_sel = 2'b00; m_rx = 8'hFF; m_ovr = 1'b0; m_busy = 1'b0;
    rd_chk("post_rst_data", 2'd0);
    rd_chk("post_rst_status", 2'd1);
    rd_chk("post_rst_div", 2'd2);
    wr(2'd1, 8'h01);
    check_cs();
    do_xfer(8'($urandom), 8'($urandom), 0, 8'h00);
    rd_chk("final_status", 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_sd.md
Name: spi_sd

Overview:
- SPI master for the two SD card slots; replaces the static ties on nSD0, nSD1, MOSI and SCLK.
- Sits directly downstream of the I/O address decoder, which asserts nSEL for $FE30-$FE33 (nIOEN low and A[7:2] == 6'b001100).
- The 6309 reads and writes four byte registers; the block shifts bytes out in SPI mode 0, MSB first, with a programmable clock.

Parameters:
- DIV_RESET, 8'd119, divider value after reset. SCLK half-period is (DIV+1) MHZ48 cycles, so the reset rate is 200 kHz for SD init.

Ports:
- MHZ48 input 1: master clock, rising edge.
- nRES input 1: asynchronous active-low reset.
- nE input 1: inverted 6309 E, generated from MHZ48 in the same device.
- RW input 1: 6309 R/W, 1 = read.
- nSEL input 1: register window select from the address decoder, active low.
- A input 2: register offset (A[1:0]).
- DIN input 8: data bus in.
- DOUT output 8: data bus out.
- DOE output 1: data bus output enable.
- nSD0 output 1: SD card 0 chip select, active low.
- nSD1 output 1: SD card 1 chip select, active low.
- MOSI output 1: SPI data out.
- SCLK output 1: SPI clock.
- MISO input 1: SPI data in.

Behaviour:
- Register map:
  - 0 DATA: a write starts a transfer. A read returns the last received byte.
  - 1 CTRL/STATUS: write bit0 = SEL0, bit1 = SEL1. Read returns {BUSY, 1'b0, OVR, 3'b0, SEL1, SEL0}.
  - 2 DIV: read/write.
  - 3 reserved: reads 8'h00, writes ignored.
- Bus capture: on every MHZ48 cycle with nE=0 & nSEL=0, latch A, RW and DIN, and set PEND.
- Bus commit: happens on the first cycle with nE=1 while PEND=1; PEND clears in the same cycle. Exactly one commit per E cycle.
- DOE = ~nE & ~nSEL & RW, combinational.
- DOUT = mux of A[1:0], combinational.
- Status read side effect: a committed read of offset 1 clears OVR. The read itself returns the pre-clear value.
- Chip selects:
  - nSD0 = ~SEL0.
  - nSD1 = ~(SEL1 & ~SEL0); SEL0 has priority, so 2'b11 asserts only nSD0.
- Transfer FSM states: IDLE, LO, HI.
  - IDLE: a DATA write commit loads TX into SHIFT, copies DIV into DCNT_RELOAD, sets BUSY=1 and MOSI=SHIFT[7], clears BITCNT, and enters LO.
  - LO: SCLK=0. The half-period counter runs DIV+1 cycles. At expiry: SCLK<=1, sample MISO into RX[0] (with RX shifted left), enter HI.
  - HI: SCLK=1. After DIV+1 cycles: SCLK<=0, BITCNT++.
    - If BITCNT was 7: DATA_RX<=RX, BUSY<=0, MOSI<=1, go to IDLE.
    - Else: SHIFT<<=1, MOSI<=next bit, go to LO.
  - Total transfer time: 16*(DIV+1) MHZ48 cycles from commit to BUSY=0.
  - BUSY rises on the cycle after the commit.
- DIV rules:
  - DIV is sampled at transfer start; writing DIV mid-transfer affects the next transfer only.
  - DIV=0 is legal and gives SCLK = 24 MHz.
- Writes while busy: DATA or CTRL writes are ignored and set OVR=1; DIV writes are accepted.
- Reads of DATA while busy return the previous received byte.
- Simultaneous events: if a status read commit and an ignored write commit would fall in the same cycle, this is impossible (one commit per cycle). OVR set has priority over clear only within an internal conflict, which cannot occur.
- Reset values: SCLK=0, MOSI=1, nSD0=1, nSD1=1, SEL=2'b00, DATA_RX=8'hFF, DIV=DIV_RESET, BUSY=0, OVR=0, PEND=0, state IDLE. DOUT is don't-care while DOE=0.
- nRES asserted mid-transfer aborts immediately: SCLK goes low and chip selects release asynchronously. The partial byte is discarded.

Test Plan:
- Reset, then read offsets 0/1/2/3 -> 8'hFF, 8'h00, 8'd119, 8'h00. Outputs: SCLK=0, MOSI=1, nSD0=nSD1=1.
- Write CTRL=8'h02, then CTRL=8'h03 -> nSD1=0/nSD0=1, then nSD0=0/nSD1=1. STATUS read = 8'h03.
- DIV=1, CTRL=1, write DATA=8'hA5, MISO model returns 8'h3C:
  - MOSI is valid before each SCLK rise and carries the bits 1,0,1,0,0,1,0,1.
  - 8 SCLK pulses, each high/low for 2 cycles.
  - BUSY is set for exactly 32 cycles.
  - DATA read = 8'h3C.
- Write DATA=8'h55 while BUSY -> transfer byte unchanged. STATUS reads 8'hA1 (BUSY|OVR|SEL0); the next STATUS read after completion = 8'h01.
- DIV=0 transfer of 8'hFF with MISO=0 -> SCLK toggles every cycle, 16 cycles busy, DATA = 8'h00.
- Pulse nRES low at bit 4 of a transfer -> same cycle: SCLK=0, nSD0=1. Afterwards BUSY=0, DATA=8'hFF, DIV=119. The next transfer runs normally.
